sobel_window_gen: RTL
=====================

Name: sobel_window_gen

Overview:
- Streaming producer of the 3x3 RGB565 pixel window consumed by the Sobel gradient stage.
- Accepts one raster-order pixel per valid cycle from the camera/frame path.
- Holds the two previous lines in line buffers and emits a registered 3x3 neighbourhood plus a valid strobe for every interior pixel position.
- Sits between the pixel source and the combinational Sobel filter.

Parameters:
- IMG_WIDTH, 320, active pixels per line (>=3)
- IMG_HEIGHT, 240, active lines per frame (>=3)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pix_in  in  16  RGB565 pixel, R[15:11] G[10:5] B[4:0]
- pix_valid  in  1  pix_in accepted this cycle
- sof  in  1  start of frame; qualified by pix_valid, marks pixel (0,0)
- window  out  16 x [8:0] unpacked  3x3 window; window[r*3+c], r=0 top (oldest line), c=0 left (oldest column)
- window_valid  out  1  window holds a complete interior neighbourhood (one-cycle strobe)
- frame_done  out  1  one-cycle pulse after pixel (IMG_WIDTH-1, IMG_HEIGHT-1) is accepted
- win_x  out  $clog2(IMG_WIDTH)  centre column of window (WIN_COORD_EN only)
- win_y  out  $clog2(IMG_HEIGHT)  centre row of window (WIN_COORD_EN only)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: window all 0x0000, window_valid=0, frame_done=0, x=0, y=0, win_x=0, win_y=0.
  - Line buffer RAM is not cleared; stale contents are masked by the y>=2 gate.
- Counters: x counts 0..IMG_WIDTH-1 on each accepted pixel.
  - At IMG_WIDTH-1, x wraps to 0 and y increments.
  - At (IMG_WIDTH-1, IMG_HEIGHT-1), both counters wrap to 0 and frame_done pulses 1 cycle later.
- sof=1 with pix_valid=1: the pixel is treated as (0,0) regardless of counter state. The partial frame is abandoned with no frame_done. sof without pix_valid is ignored.
- Line buffers: lb0 holds line y-1 and lb1 holds line y-2, each IMG_WIDTH x 16, single write port, read address = x.
  - On accept: lb0[x]<=pix_in and lb1[x]<=old lb0[x].
- Pipeline stage 1 (accept cycle): read lb0[x] and lb1[x] using a synchronous RAM read; register pix_in, x, y and an accept flag.
- Pipeline stage 2: on a stage-1 accept, shift the window columns left: c0<=c1, c1<=c2, new c2 = {lb1, lb0, pix}. Row 0 comes from lb1 and row 2 from the pixel.
- window_valid=1 exactly 2 cycles after accepting pixel (x,y) with x>=2 and y>=2; the window centre is (x-1, y-1).
  - Asserts IMG_WIDTH-2 times per line and (IMG_WIDTH-2)*(IMG_HEIGHT-2) times per frame.
- Bubbles (pix_valid=0): no shift and no counter change; window holds and window_valid=0.
- No window is produced for x<2 at the start of a line. This prevents the previous line's right edge from mixing with the new line's left edge.
- No backpressure: the downstream stage must consume every window_valid.
- Reset mid-frame: the pipeline flushes and no window_valid is asserted until 2 new full lines have arrived.

Optional Feature:
- Macro: SOBEL_WIN_COORD_EN.
- Defined: win_x/win_y ports exist and are registered alongside window, giving the centre coordinates (x-1, y-1). They are valid only when window_valid=1.
- Undefined: the ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package sobel_pkg:
  - typedef rgb565_t (16-bit packed struct r/g/b)
  - typedef window_t (rgb565_t [8:0])
  - localparam LCD_WIDTH=320, LCD_HEIGHT=240
- Sub-module sobel_line_buffer: IMG_WIDTH-deep, 16-bit, single-clock RAM with write-then-read-old (read-first) semantics and synchronous read. Instantiate it twice.

Test Plan:
- Common setup: IMG_WIDTH=5, IMG_HEIGHT=4; pix = {8'(y), 8'(x)}; continuous pix_valid; sof on the first pixel.
- Basic window: first window_valid arrives 2 cycles after pixel (2,2) is accepted, with window[0]=0x0000, [1]=0x0001, [2]=0x0002, [4]=0x0101, [8]=0x0202, [6]=0x0200.
- Count and ordering: 6 window_valid strobes per frame, no strobe for x<2 or y<2; last window centre is (3,2) with [8]=0x0304. frame_done pulses once, 1 cycle after pixel (4,3).
- Bubbles: insert pix_valid=0 after every pixel. Window contents match the continuous case, window_valid count is still 6, and window holds during bubbles.
- sof resync: assert sof at pixel (3,1) of frame 1. Frame 1 produces no frame_done, the next 5x4 pixels produce 6 correct windows, and frame_done follows.
- Reset mid-frame: assert rst for 1 cycle at pixel (2,3). Outputs go to 0, and the next frame after sof produces exactly 6 correct windows with no stale data.
- SOBEL_WIN_COORD_EN build: win_x/win_y sequence (1,1), (2,1), (3,1), (1,2), (2,2), (3,2) aligned with window_valid.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the Sobel window generator.
package sobel_pkg;

    localparam int unsigned LCD_WIDTH  = 320;
    localparam int unsigned LCD_HEIGHT = 240;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef rgb565_t [8:0] window_t;

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out bundle of the Sobel window generator.
// Macro SOBEL_WIN_COORD_EN adds the win_x/win_y centre-coordinate signals.
interface sobel_window_gen_if
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = LCD_WIDTH,
    parameter int unsigned IMG_HEIGHT = LCD_HEIGHT
);

    rgb565_t pix_in;
    logic    pix_valid;
    logic    sof;
    rgb565_t window [9];
    logic    window_valid;
    logic    frame_done;

`ifdef SOBEL_WIN_COORD_EN
    localparam int unsigned XW = $clog2(IMG_WIDTH);
    localparam int unsigned YW = $clog2(IMG_HEIGHT);

    logic [XW-1:0] win_x;
    logic [YW-1:0] win_y;

    modport master (
        output pix_in, pix_valid, sof,
        input  window, window_valid, frame_done, win_x, win_y
    );
    modport slave (
        input  pix_in, pix_valid, sof,
        output window, window_valid, frame_done, win_x, win_y
    );
`else
    modport master (
        output pix_in, pix_valid, sof,
        input  window, window_valid, frame_done
    );
    modport slave (
        input  pix_in, pix_valid, sof,
        output window, window_valid, frame_done
    );
`endif

endinterface

// File: rtl/sobel_line_buffer.sv
// One-line pixel store: single write port, synchronous read-first read port.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned DEPTH = LCD_WIDTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  rgb565_t       wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output rgb565_t       rdata
);

    rgb565_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-edge read returns the contents before any write at that address.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Streams a registered 3x3 RGB565 neighbourhood for every interior pixel.
// Macro SOBEL_WIN_COORD_EN adds registered centre coordinates win_x/win_y.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = LCD_WIDTH,
    parameter int unsigned IMG_HEIGHT = LCD_HEIGHT
) (
    input logic               clk,
    input logic               rst,
    sobel_window_gen_if.slave bus
);

    localparam int unsigned XW = $clog2(IMG_WIDTH);
    localparam int unsigned YW = $clog2(IMG_HEIGHT);

    logic          accept;
    logic [XW-1:0] x_q, cur_x;
    logic [YW-1:0] y_q, cur_y;
    logic          last_x, last_y;
    logic          frame_done_q;

    rgb565_t       lb0_rd, lb1_rd;

    logic          s1_acc;
    rgb565_t       s1_pix;
    logic [XW-1:0] s1_x;
    logic [YW-1:0] s1_y;

    window_t       window_q;
    logic          window_valid_q;

    assign accept = bus.pix_valid;

    // sof forces the accepted pixel to (0,0), abandoning any partial frame.
    always_comb begin
        cur_x  = bus.sof ? '0 : x_q;
        cur_y  = bus.sof ? '0 : y_q;
        last_x = (cur_x == XW'(IMG_WIDTH - 1));
        last_y = (cur_y == YW'(IMG_HEIGHT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= accept && last_x && last_y;
            if (accept) begin
                if (last_x) begin
                    x_q <= '0;
                    y_q <= last_y ? '0 : cur_y + YW'(1);
                end else begin
                    x_q <= cur_x + XW'(1);
                    y_q <= cur_y;
                end
            end
        end
    end

    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .AW    (XW)
    ) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .waddr (cur_x),
        .wdata (bus.pix_in),
        .re    (accept),
        .raddr (cur_x),
        .rdata (lb0_rd)
    );

    // lb1 takes the old lb0 word one cycle late, once the read-first data is out.
    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .AW    (XW)
    ) u_lb1 (
        .clk   (clk),
        .we    (s1_acc),
        .waddr (s1_x),
        .wdata (lb0_rd),
        .re    (accept),
        .raddr (cur_x),
        .rdata (lb1_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_acc <= 1'b0;
            s1_pix <= '0;
            s1_x   <= '0;
            s1_y   <= '0;
        end else begin
            s1_acc <= accept;
            if (accept) begin
                s1_pix <= bus.pix_in;
                s1_x   <= cur_x;
                s1_y   <= cur_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            window_q       <= '0;
            window_valid_q <= 1'b0;
        end else begin
            window_valid_q <= s1_acc && (s1_x >= XW'(2)) && (s1_y >= YW'(2));
            if (s1_acc) begin
                for (int r = 0; r < 3; r++) begin
                    window_q[r*3]   <= window_q[r*3+1];
                    window_q[r*3+1] <= window_q[r*3+2];
                end
                window_q[2] <= lb1_rd;
                window_q[5] <= lb0_rd;
                window_q[8] <= s1_pix;
            end
        end
    end

`ifdef SOBEL_WIN_COORD_EN
    logic [XW-1:0] win_x_q;
    logic [YW-1:0] win_y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_x_q <= '0;
            win_y_q <= '0;
        end else if (s1_acc) begin
            win_x_q <= s1_x - XW'(1);
            win_y_q <= s1_y - YW'(1);
        end
    end

    assign bus.win_x = win_x_q;
    assign bus.win_y = win_y_q;
`endif

    for (genvar i = 0; i < 9; i++) begin : g_win_out
        assign bus.window[i] = window_q[i];
    end

    assign bus.window_valid = window_valid_q;
    assign bus.frame_done   = frame_done_q;

endmodule
